// File: rtl/vector_register_group_file.sv
// Vector register file with LMUL register grouping and streamed, masked multi-beat write-back.
// Optional feature: define VRF_TAIL_AGNOSTIC_EN to fill tail elements of written registers with all-ones.

`ifndef ONE_BYTE
`define ONE_BYTE 3'b000
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'b001
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'b010
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'b011
`endif
`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'b01
`endif

module vector_register_group_file #(
  parameter int LEN         = 32,
  parameter int VECTOR_SIZE = 8,
  parameter int REG_NUM     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy_in,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [4:0]                 rs3,
  output logic [LEN*VECTOR_SIZE-1:0] rs1_data,
  output logic [LEN*VECTOR_SIZE-1:0] rs2_data,
  output logic [LEN*VECTOR_SIZE-1:0] rs3_data,
  output logic [LEN*VECTOR_SIZE-1:0] v0_data,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [4:0]                 rd,
  input  logic [1:0]                 lmul,
  input  logic [2:0]                 data_type,
  input  logic [LEN-1:0]             length,
  input  logic                       vm,
  input  logic                       wdata_valid,
  output logic                       wdata_ready,
  input  logic [LEN*VECTOR_SIZE-1:0] wdata,
  output logic [31:0]                busy,
  output logic [1:0]                 rf_status,
  output logic                       cmd_err
);

  localparam int VLEN   = LEN * VECTOR_SIZE;
  localparam int VBYTES = VLEN / 8;
  localparam int GW     = $clog2(VLEN);
  localparam int VLW    = GW + 1;

`ifdef VRF_TAIL_AGNOSTIC_EN
  localparam logic TAIL_FILL = 1'b1;
`else
  localparam logic TAIL_FILL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

  state_e          state_q, state_d;
  logic [VLEN-1:0] regFile_q [REG_NUM];
  logic [4:0]      rs1_q, rs2_q, rs3_q;
  logic [4:0]      rd_q;
  logic [1:0]      lmul_q;
  logic [1:0]      sew_q;
  logic [VLW-1:0]  vl_q;
  logic            vm_q;
  logic [VLEN-1:0] mask_q;
  logic [2:0]      beat_q;
  logic [31:0]     busy_q;
  logic            cmdErr_q;

  logic [3:0]        groupSize;
  logic [VLW-1:0]    groupElems;
  logic [VLW-1:0]    clampedVl;
  logic [31:0]       groupBits;
  logic              misaligned;
  logic              badType;
  logic              cmdFire;
  logic              cmdAccept;
  logic              beatFire;
  logic              lastBeat;
  logic [4:0]        wrIdx;
  logic [VBYTES-1:0] byteWe;
  logic [VLEN-1:0]   byteData;

  // The SEW encodings are 0..3, so their low two bits double as log2(bytes per element).
  always_comb begin
    groupSize  = 4'd1 << lmul;
    misaligned = (rd & 5'(groupSize - 4'd1)) != 5'd0;
    case (data_type)
      `ONE_BYTE, `TWO_BYTE, `FOUR_BYTE, `EIGHT_BYTE: badType = 1'b0;
      default:                                       badType = 1'b1;
    endcase
    groupElems = VLW'((VBYTES << lmul) >> data_type[1:0]);
    clampedVl  = (length >= LEN'(groupElems)) ? groupElems : VLW'(length);
    groupBits  = 32'((9'd1 << groupSize) - 9'd1);
    cmdFire    = rdy_in && cmd_valid && (state_q == IDLE) && !rst;
    cmdAccept  = cmdFire && !misaligned && !badType;
  end

  assign beatFire = rdy_in && wdata_valid && (state_q == WRITE) && !rst;
  assign lastBeat = beat_q == 3'((4'd1 << lmul_q) - 4'd1);
  assign wrIdx    = rd_q + 5'(beat_q);

  // Byte k of beat b belongs to global element (b*VBYTES + k) >> log2(SEW bytes).
  for (genvar k = 0; k < VBYTES; k++) begin : gByte
    logic [GW-1:0] byteIdx;
    logic [GW-1:0] elemIdx;
    logic          inBody;
    assign byteIdx   = GW'(beat_q) * GW'(VBYTES) + GW'(k);
    assign elemIdx   = byteIdx >> sew_q;
    assign inBody    = {1'b0, elemIdx} < vl_q;
    assign byteWe[k] = beatFire && (inBody ? (vm_q || mask_q[elemIdx]) : TAIL_FILL);
    assign byteData[8*k +: 8] = inBody ? wdata[8*k +: 8] : 8'hFF;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < VBYTES; k++) begin
      if (byteWe[k]) regFile_q[wrIdx][8*k +: 8] <= byteData[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmdAccept) state_d = (length == '0) ? DONE : WRITE;
      WRITE:   if (beatFire && lastBeat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    rf_status   = `RF_NOP;
    case (state_q)
      IDLE:    cmd_ready   = 1'b1;
      WRITE:   wdata_ready = 1'b1;
      DONE:    rf_status   = `RF_FINISHED;
      default: ;
    endcase
  end

  // Busy bits stay up through the DONE cycle so issue logic never sees a gap before completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
      rd_q     <= '0;
      lmul_q   <= '0;
      sew_q    <= '0;
      vl_q     <= '0;
      vm_q     <= 1'b0;
      mask_q   <= '0;
      beat_q   <= '0;
      busy_q   <= '0;
      cmdErr_q <= 1'b0;
    end else if (rdy_in) begin
      rs1_q    <= rs1;
      rs2_q    <= rs2;
      rs3_q    <= rs3;
      cmdErr_q <= cmdFire && !cmdAccept;
      if (cmdAccept) begin
        rd_q   <= rd;
        lmul_q <= lmul;
        sew_q  <= data_type[1:0];
        vl_q   <= clampedVl;
        vm_q   <= vm;
        mask_q <= regFile_q[0];
        beat_q <= '0;
        if (length != '0) busy_q <= groupBits << rd;
      end else if (beatFire && !lastBeat) begin
        beat_q <= beat_q + 3'd1;
      end
      if (state_q == DONE) busy_q <= '0;
    end
  end

  assign rs1_data = regFile_q[rs1_q];
  assign rs2_data = regFile_q[rs2_q];
  assign rs3_data = regFile_q[rs3_q];
  assign v0_data  = regFile_q[0];
  assign busy     = busy_q;
  assign cmd_err  = cmdErr_q;

endmodule

// File: tb/tb_vector_register_group_file.sv
// Scoreboard bench for vector_register_group_file: directed commands, probe and event queues checked by a monitor.
// Tail expectations follow VRF_TAIL_AGNOSTIC_EN when it is defined for the build.

`ifndef ONE_BYTE
`define ONE_BYTE 3'b000
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'b001
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'b010
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'b011
`endif
`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'b01
`endif

module tb_vector_register_group_file;

  localparam int LEN         = 32;
  localparam int VECTOR_SIZE = 8;
  localparam int VLEN        = LEN * VECTOR_SIZE;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy_in;
  logic [4:0]      rs1, rs2, rs3;
  logic [VLEN-1:0] rs1_data, rs2_data, rs3_data, v0_data;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [4:0]      rd;
  logic [1:0]      lmul;
  logic [2:0]      data_type;
  logic [LEN-1:0]  length;
  logic            vm;
  logic            wdata_valid;
  logic            wdata_ready;
  logic [VLEN-1:0] wdata;
  logic [31:0]     busy;
  logic [1:0]      rf_status;
  logic            cmd_err;

  always #5 clk = ~clk;

  vector_register_group_file #(.LEN(LEN), .VECTOR_SIZE(VECTOR_SIZE), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data), .v0_data(v0_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rd(rd), .lmul(lmul), .data_type(data_type), .length(length), .vm(vm),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .busy(busy), .rf_status(rf_status), .cmd_err(cmd_err)
  );

  typedef enum int {SIG_BUSY, SIG_CMD_READY, SIG_WDATA_READY, SIG_RF_STATUS, SIG_CMD_ERR, SIG_RS1_DATA, SIG_V0} sig_e;
  typedef enum int {EV_FINISH, EV_ERR} ev_e;
  typedef struct { string name; sig_e sig; logic [VLEN-1:0] exp; } probe_t;
  typedef struct { string name; ev_e ev; } evt_t;

  probe_t          probeQ[$];
  evt_t            evQ[$];
  int              testsRun = 0;
  int              testsFailed = 0;
  logic [VLEN-1:0] beatBuf [8];

  localparam logic [VLEN-1:0] S1_BEAT =
    256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

`ifdef VRF_TAIL_AGNOSTIC_EN
  localparam logic [VLEN-1:0] S2_V9 = {{4{32'hFFFFFFFF}}, {4{32'hAAAAAAAA}}};
  localparam logic [VLEN-1:0] S3_V2 = {{24{8'hFF}}, 64'h00CC00CC_00CC00CC};
`else
  localparam logic [VLEN-1:0] S2_V9 = {{4{32'h00000000}}, {4{32'hAAAAAAAA}}};
  localparam logic [VLEN-1:0] S3_V2 = {{24{8'h00}}, 64'h00CC00CC_00CC00CC};
`endif

  // Monitor: compares every probe queued this cycle, and pairs each status pulse with the next expected event.
  always @(negedge clk) begin : monitor
    probe_t          p;
    evt_t            e;
    ev_e             actEv;
    logic [VLEN-1:0] act;
    while (probeQ.size() > 0) begin
      p   = probeQ.pop_front();
      act = '0;
      case (p.sig)
        SIG_BUSY:        act[31:0] = busy;
        SIG_CMD_READY:   act[0]    = cmd_ready;
        SIG_WDATA_READY: act[0]    = wdata_ready;
        SIG_RF_STATUS:   act[1:0]  = rf_status;
        SIG_CMD_ERR:     act[0]    = cmd_err;
        SIG_RS1_DATA:    act       = rs1_data;
        SIG_V0:          act       = v0_data;
        default:         act       = 'x;
      endcase
      testsRun++;
      if (act !== p.exp) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %h, expected %h", p.name, act, p.exp);
      end
    end
    if (rf_status === `RF_FINISHED || cmd_err === 1'b1) begin
      actEv = (cmd_err === 1'b1) ? EV_ERR : EV_FINISH;
      testsRun++;
      if (evQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected pulse: got event kind %0d, expected none", actEv);
      end else begin
        e = evQ.pop_front();
        if (e.ev != actEv) begin
          testsFailed++;
          $display("[TB] FAIL %s: got event kind %0d, expected %0d", e.name, actEv, e.ev);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectSig(input string name, input sig_e s, input logic [VLEN-1:0] e);
    probe_t p;
    p.name = name;
    p.sig  = s;
    p.exp  = e;
    probeQ.push_back(p);
  endtask

  task automatic pushEvent(input string name, input ev_e ev);
    evt_t e;
    e.name = name;
    e.ev   = ev;
    evQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [4:0] rdI, input logic [1:0] lmulI, input logic [2:0] typeI,
                               input logic [31:0] vlI, input logic vmI);
    cmd_valid = 1'b1;
    rd        = rdI;
    lmul      = lmulI;
    data_type = typeI;
    length    = vlI;
    vm        = vmI;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] idx, input logic [VLEN-1:0] e);
    rs1 = idx;
    step();
    expectSig(name, SIG_RS1_DATA, e);
    step();
  endtask

  task automatic writeGroup(input string name, input logic [4:0] rdI, input logic [1:0] lmulI,
                            input logic [2:0] typeI, input logic [31:0] vlI, input logic vmI, input int nBeats);
    applyStimulus(rdI, lmulI, typeI, vlI, vmI);
    pushEvent({name, " finish"}, EV_FINISH);
    for (int b = 0; b < nBeats; b++) begin
      wdata_valid = 1'b1;
      wdata       = beatBuf[b];
      step();
    end
    wdata_valid = 1'b0;
    wdata       = '0;
    step();
  endtask

  initial begin : stim
    rst = 1'b1; rdy_in = 1'b1; cmd_valid = 1'b0; rd = '0; lmul = '0; data_type = `FOUR_BYTE;
    length = '0; vm = 1'b1; wdata_valid = 1'b0; wdata = '0; rs1 = '0; rs2 = 5'd1; rs3 = 5'd2;
    step();
    step();
    expectSig("reset busy", SIG_BUSY, '0);
    expectSig("reset cmd_ready", SIG_CMD_READY, 1);
    expectSig("reset wdata_ready", SIG_WDATA_READY, 0);
    expectSig("reset rf_status", SIG_RF_STATUS, `RF_NOP);
    expectSig("reset cmd_err", SIG_CMD_ERR, 0);
    step();
    rst = 1'b0;
    step();

    // Single register write, SEW32, full length.
    expectSig("s1 cmd_ready idle", SIG_CMD_READY, 1);
    applyStimulus(5'd4, 2'd0, `FOUR_BYTE, 32'd8, 1'b1);
    expectSig("s1 busy cycle1", SIG_BUSY, 32'h0000_0010);
    expectSig("s1 wdata_ready", SIG_WDATA_READY, 1);
    expectSig("s1 cmd_ready busy", SIG_CMD_READY, 0);
    pushEvent("s1 finish", EV_FINISH);
    wdata_valid = 1'b1;
    wdata       = S1_BEAT;
    step();
    wdata_valid = 1'b0;
    expectSig("s1 rf_status finished", SIG_RF_STATUS, `RF_FINISHED);
    expectSig("s1 busy cycle2", SIG_BUSY, 32'h0000_0010);
    expectSig("s1 wdata_ready done", SIG_WDATA_READY, 0);
    step();
    expectSig("s1 busy cleared", SIG_BUSY, '0);
    expectSig("s1 cmd_ready back", SIG_CMD_READY, 1);
    expectSig("s1 rf_status nop", SIG_RF_STATUS, `RF_NOP);
    step();
    checkOutput("s1 v4 data", 5'd4, S1_BEAT);

    // Group of two with vl clamping, then partial write with a stall and a rdy_in hold.
    for (int b = 0; b < 2; b++) beatBuf[b] = {32{8'h33}};
    writeGroup("s2 preload", 5'd8, 2'd1, `FOUR_BYTE, 32'd16, 1'b1, 2);
    for (int b = 0; b < 2; b++) beatBuf[b] = '0;
    writeGroup("s2 clamp", 5'd8, 2'd1, `FOUR_BYTE, 32'h0000_0203, 1'b1, 2);
    checkOutput("s2 clamp v9 zero", 5'd9, '0);
    applyStimulus(5'd8, 2'd1, `FOUR_BYTE, 32'd12, 1'b1);
    pushEvent("s2 finish", EV_FINISH);
    wdata_valid = 1'b0;
    step();
    wdata_valid = 1'b1;
    wdata       = {32{8'hAA}};
    rdy_in      = 1'b0;
    step();
    expectSig("s2 busy held", SIG_BUSY, 32'h0000_0300);
    expectSig("s2 wdata_ready held", SIG_WDATA_READY, 1);
    rdy_in = 1'b1;
    step();
    step();
    wdata_valid = 1'b0;
    expectSig("s2 rf_status finished", SIG_RF_STATUS, `RF_FINISHED);
    step();
    checkOutput("s2 v8 data", 5'd8, {8{32'hAAAAAAAA}});
    checkOutput("s2 v9 tail", 5'd9, S2_V9);

    // Masked byte write driven by v0.
    beatBuf[0] = 256'h55;
    writeGroup("s3 v0 preload", 5'd0, 2'd0, `FOUR_BYTE, 32'd8, 1'b1, 1);
    beatBuf[0] = '0;
    writeGroup("s3 v2 preload", 5'd2, 2'd0, `FOUR_BYTE, 32'd8, 1'b1, 1);
    expectSig("s3 v0 mask", SIG_V0, 256'h55);
    beatBuf[0] = {32{8'hCC}};
    writeGroup("s3 masked", 5'd2, 2'd0, `ONE_BYTE, 32'd8, 1'b0, 1);
    checkOutput("s3 v2 masked", 5'd2, S3_V2);

    // Rejected commands: misaligned group and unsupported element type.
    beatBuf[0] = {32{8'h77}};
    writeGroup("s4 v3 preload", 5'd3, 2'd0, `FOUR_BYTE, 32'd8, 1'b1, 1);
    applyStimulus(5'd3, 2'd1, `FOUR_BYTE, 32'd8, 1'b1);
    pushEvent("s4 misaligned err", EV_ERR);
    expectSig("s4 cmd_err pulse", SIG_CMD_ERR, 1);
    expectSig("s4 busy none", SIG_BUSY, '0);
    expectSig("s4 cmd_ready idle", SIG_CMD_READY, 1);
    wdata_valid = 1'b1;
    wdata       = {32{8'hEE}};
    step();
    wdata_valid = 1'b0;
    expectSig("s4 cmd_err cleared", SIG_CMD_ERR, 0);
    expectSig("s4 wdata_ready idle", SIG_WDATA_READY, 0);
    step();
    checkOutput("s4 v3 unchanged", 5'd3, {32{8'h77}});
    applyStimulus(5'd4, 2'd0, 3'b100, 32'd8, 1'b1);
    pushEvent("s4 bad type err", EV_ERR);
    expectSig("s4 bad type cmd_err", SIG_CMD_ERR, 1);
    step();
    checkOutput("s4 v4 unchanged", 5'd4, S1_BEAT);

    // Zero length goes straight to DONE.
    applyStimulus(5'd5, 2'd0, `FOUR_BYTE, 32'd0, 1'b1);
    pushEvent("s5 finish", EV_FINISH);
    expectSig("s5 rf_status finished", SIG_RF_STATUS, `RF_FINISHED);
    expectSig("s5 wdata_ready", SIG_WDATA_READY, 0);
    expectSig("s5 busy none", SIG_BUSY, '0);
    step();
    expectSig("s5 cmd_ready back", SIG_CMD_READY, 1);
    expectSig("s5 wdata_ready after", SIG_WDATA_READY, 0);
    step();

    // Reset in the middle of a four-register group.
    for (int b = 0; b < 4; b++) beatBuf[b] = {32{8'h5A}};
    writeGroup("s6 preload", 5'd16, 2'd2, `FOUR_BYTE, 32'd32, 1'b1, 4);
    applyStimulus(5'd16, 2'd2, `FOUR_BYTE, 32'd32, 1'b1);
    expectSig("s6 busy group", SIG_BUSY, 32'h000F_0000);
    wdata_valid = 1'b1;
    wdata       = {32{8'hC3}};
    step();
    rst   = 1'b1;
    wdata = {32{8'h3C}};
    step();
    rst         = 1'b0;
    wdata_valid = 1'b0;
    expectSig("s6 busy after reset", SIG_BUSY, '0);
    expectSig("s6 cmd_ready after reset", SIG_CMD_READY, 1);
    expectSig("s6 wdata_ready after reset", SIG_WDATA_READY, 0);
    expectSig("s6 rf_status after reset", SIG_RF_STATUS, `RF_NOP);
    step();
    checkOutput("s6 v16 new", 5'd16, {32{8'hC3}});
    checkOutput("s6 v17 old", 5'd17, {32{8'h5A}});
    checkOutput("s6 v19 old", 5'd19, {32{8'h5A}});

    step();
    step();
    testsRun++;
    if (evQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL pending events: got %0d outstanding, expected 0", evQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
